// File: rtl/button_pulse_gen_if.sv
// Button conditioner bundle: raw button in, debounced level and press strobe out.
interface button_pulse_gen_if;
  logic btn_raw;
  logic level;
  logic pulse;

  modport master (output btn_raw, input level, input pulse);
  modport slave  (input btn_raw, output level, output pulse);
endinterface

// File: rtl/button_pulse_gen.sv
// Debounces a bouncing pushbutton into a clean level plus a single-cycle
// press strobe (one physical press -> exactly one pulse).
module button_pulse_gen #(
  parameter int DIV    = 100000,
  parameter int STABLE = 5
) (
  input  logic               clk,
  input  logic               rst,
  button_pulse_gen_if.slave  btn
);

  localparam int PW = $clog2(DIV);
  localparam int SW = $clog2(STABLE + 1);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(STABLE - 1);

  typedef enum logic [1:0] {LOW, ARM_HI, HIGH, ARM_LO} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic            s1_q, btn_s_q;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic            tick;
  logic            last_tick;

  // Two-flop synchronizer for the asynchronous button pin
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      s1_q    <= btn.btn_raw;
      btn_s_q <= s1_q;
    end
  end

  assign tick      = (pcnt_q == PMAX);
  assign last_tick = tick && (scnt_q == SMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      pcnt_q  <= '0;
      scnt_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      LOW: begin
        if (btn_s_q) begin
          state_d = ARM_HI;
          pcnt_d  = '0;
          scnt_d  = '0;
        end
      end
      ARM_HI: begin
        if (!btn_s_q) begin
          state_d = LOW;
        end else if (tick) begin
          pcnt_d = '0;
          scnt_d = scnt_q + 1'b1;
          if (last_tick) state_d = HIGH;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (!btn_s_q) begin
          state_d = ARM_LO;
          pcnt_d  = '0;
          scnt_d  = '0;
        end
      end
      ARM_LO: begin
        if (btn_s_q) begin
          state_d = HIGH;
        end else if (tick) begin
          pcnt_d = '0;
          scnt_d = scnt_q + 1'b1;
          if (last_tick) state_d = LOW;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: state_d = LOW;
    endcase

    // Outputs registered from the next state so they line up with the transition edge
    level_d = (state_d == HIGH) || (state_d == ARM_LO);
    pulse_d = (state_q == ARM_HI) && (state_d == HIGH);
  end

  assign btn.level = level_q;
  assign btn.pulse = pulse_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: run-length reference model plus directed and random steps.
module tb_button_pulse_gen;
  localparam int DIV    = 4;
  localparam int STABLE = 3;
  localparam int WIN    = DIV * STABLE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  button_pulse_gen_if bus();

  button_pulse_gen #(.DIV(DIV), .STABLE(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .btn (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: the accepted level flips once the synchronized input has
  // disagreed with it for WIN+1 consecutive edges; a rising flip gives a pulse.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0, m_pulse = 1'b0;
  int   m_run = 0;

  always @(posedge clk) begin
    int   run_n;
    logic lvl_n, pls_n;
    if (rst) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_level <= 1'b0; m_pulse <= 1'b0; m_run <= 0;
    end else begin
      run_n = (m_s2 != m_level) ? m_run + 1 : 0;
      lvl_n = m_level;
      pls_n = 1'b0;
      if (run_n == WIN + 1) begin
        lvl_n = m_s2;
        pls_n = m_s2;
        run_n = 0;
      end
      m_run   <= run_n;
      m_level <= lvl_n;
      m_pulse <= pls_n;
      m_s2    <= m_s1;
      m_s1    <= bus.btn_raw;
    end
  end

  // Mod-10 counter enabled by the press strobe
  logic [3:0] ctr_q;
  logic       ctr_clr = 1'b0;
  always @(posedge clk) begin
    if (rst || ctr_clr) ctr_q <= 4'd0;
    else if (bus.pulse) ctr_q <= (ctr_q == 4'd9) ? 4'd0 : ctr_q + 4'd1;
  end

  int   cyc = 0;
  int   npulse = 0;
  int   last_p = -1;
  logic prev_p = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("level", 32'(bus.level), 32'(m_level));
    chk("pulse", 32'(bus.pulse), 32'(m_pulse));
    chk("pulse_gap", 32'(prev_p & bus.pulse), 32'd0);
    prev_p = bus.pulse;
    if (bus.pulse === 1'b1) begin
      npulse++;
      last_p = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int t0, p0;
    bus.btn_raw = 1'b0;
    rst = 1'b1;
    run(2);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_pulse", 32'(bus.pulse), 32'd0);
    rst = 1'b0;
    run(5);

    // Clean press
    p0 = npulse; t0 = cyc;
    bus.btn_raw = 1'b1;
    run(40);
    chk("press_count", npulse - p0, 1);
    chk("press_lat", last_p - t0, WIN + 3);
    chk("press_level", 32'(bus.level), 32'd1);
    bus.btn_raw = 1'b0;
    run(20);

    // Bounce then settle high
    p0 = npulse;
    for (int b = 0; b < 4; b++) begin
      bus.btn_raw = (b % 2 == 0);
      run(3);
    end
    t0 = cyc;
    bus.btn_raw = 1'b1;
    run(30);
    chk("bounce_count", npulse - p0, 1);
    chk("bounce_lat", last_p - t0, WIN + 3);

    // Release glitch, then clean release
    p0 = npulse;
    bus.btn_raw = 1'b0;
    run(5);
    bus.btn_raw = 1'b1;
    run(20);
    chk("glitch_level", 32'(bus.level), 32'd1);
    chk("glitch_pulse", npulse - p0, 0);
    bus.btn_raw = 1'b0;
    run(WIN + 2);
    chk("rel_hold", 32'(bus.level), 32'd1);
    run(1);
    chk("rel_fall", 32'(bus.level), 32'd0);
    chk("rel_pulse", npulse - p0, 0);
    run(10);

    // Reset while held high
    bus.btn_raw = 1'b1;
    run(20);
    chk("pre_rst_level", 32'(bus.level), 32'd1);
    rst = 1'b1;
    run(1);
    chk("midrst_level", 32'(bus.level), 32'd0);
    rst = 1'b0;
    p0 = npulse; t0 = cyc;
    run(25);
    chk("midrst_count", npulse - p0, 1);
    chk("midrst_lat", last_p - t0, WIN + 3);
    bus.btn_raw = 1'b0;
    run(20);

    // Counter hookup: seven presses
    ctr_clr = 1'b1;
    run(1);
    ctr_clr = 1'b0;
    for (int p = 0; p < 7; p++) begin
      bus.btn_raw = 1'b1;
      run(20);
      bus.btn_raw = 1'b0;
      run(20);
    end
    chk("ctr_q", 32'(ctr_q), 32'd7);

    // Random bounce patterns with occasional reset
    for (int k = 0; k < 150; k++) begin
      bus.btn_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        run(1);
        rst = 1'b0;
      end
      run($urandom_range(1, 18));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
